reg_bus_master: RTL and testbench
=================================

# reg_bus_master

Initiator for the USB register bus: it performs the other end of the `reg_address`/`reg_bytecnt`/`reg_read`/`reg_write` protocol that register blocks such as `reg_trace` respond to. A simple command port plus valid/ready byte streams are turned into byte-serial register accesses. Used for on-FPGA self-configuration and for bench-driving register blocks without the USB front end.

## Interface
Parameters:
- pADDR_WIDTH, 21, full register address width.
- pBYTECNT_SIZE, 7, byte-count field width; max burst 2^pBYTECNT_SIZE bytes.
- pTIMEOUT, 1024, stall cycles before abort (timeout build only).

Ports:
- usb_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high exactly when state is IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_address  in  pADDR_WIDTH-pBYTECNT_SIZE  register address.
- cmd_len  in  pBYTECNT_SIZE  burst length minus one.
- wdata  in  8  write byte.
- wvalid  in  1  write byte valid.
- wready  out  1  write byte accepted.
- rdata  out  8  read byte.
- rvalid  out  1  read byte valid.
- rready  in  1  read byte consumed.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  qualifies done; 1 means aborted.
- reg_address  out  pADDR_WIDTH-pBYTECNT_SIZE  bus address.
- reg_bytecnt  out  pBYTECNT_SIZE  bus byte index.
- reg_write_data  out  8  bus write byte.
- reg_read_data  in  8  bus read byte, valid the cycle after reg_read.
- reg_read  out  1  read strobe.
- reg_write  out  1  write strobe.
- reg_addrvalid  out  1  address valid.

## Operation
- Reset values: all outputs 0 except cmd_ready = 1 (state IDLE). Reset asserted mid-burst aborts immediately: strobes and reg_addrvalid drop asynchronously, no done pulse, and the burst is not resumed.
- States: IDLE, SETUP, WR, WSTB, RD, RCAP, RHOLD, DONE.
- IDLE: on cmd_valid&cmd_ready, latch address, direction and last = cmd_len; index = 0; go to SETUP.
- SETUP: one cycle; reg_addrvalid = 1, reg_bytecnt = 0, no strobe; go to WR if write, else RD.
- WR: wready = 1. On wvalid, latch wdata into reg_write_data and go to WSTB.
- WSTB: reg_write = 1 for exactly one cycle, reg_bytecnt = index. If index == last go to DONE, else increment index and go to WR.
- RD: reg_read = 1 for one cycle, reg_bytecnt = index; go to RCAP.
- RCAP: strobes low; sample reg_read_data on the closing edge; go to RHOLD.
- RHOLD: rvalid = 1 and rdata held stable until rready. On rready, if index == last go to DONE, else increment index and go to RD.
- DONE: reg_addrvalid = 0, done = 1 for one cycle; go to IDLE.
- reg_addrvalid is 1 in every state from SETUP through RHOLD, and reg_address is held constant for the whole burst.
- Burst arithmetic: index runs 0..last and never wraps, because cmd_len = 2^pBYTECNT_SIZE-1 gives the maximum burst.
- cmd_valid while busy is ignored (cmd_ready = 0). A single-byte burst is cmd_len = 0.
- wready and rvalid are never both high; reg_read and reg_write are never both high.

## Timing
- Command accept to first strobe: 2 cycles (accept edge, SETUP).
- Write byte: minimum 2 cycles (WR, WSTB).
- Read byte: minimum 3 cycles (RD, RCAP, RHOLD with rready already high).
- Last strobe to done: WSTB→DONE is 1 cycle; RHOLD→DONE is 1 cycle after rready.
- cmd_ready returns high the cycle after done.

## Configuration
- REG_MASTER_TIMEOUT_EN defined:
  - A down-counter loads pTIMEOUT on entry to WR or RHOLD.
  - It decrements each cycle the state waits (no wvalid, or no rready).
  - At 0 the burst aborts to DONE with err = 1. The remaining bytes are not transferred, and a pending rdata is discarded.
- REG_MASTER_TIMEOUT_EN undefined:
  - The block waits indefinitely.
  - err is tied 0 and the counter logic is absent.

## Structure
- reg_master_pkg holds:
  - the state enum;
  - the default widths;
  - the pTIMEOUT default.
- Optional sub-module reg_master_timeout is the stall counter, instantiated only under REG_MASTER_TIMEOUT_EN.
- The FSM, index counter and bus registers stay in the top module.

## Test plan
- Write 4 bytes 0x11,0x22,0x33,0x44 to a pattern register (cmd_len = 3).
  - Expect reg_write pulses at reg_bytecnt 0,1,2,3 with matching data.
  - Expect done with err = 0.
  - A read-back burst returns the same 4 bytes.
- Read the 8-byte name register (cmd_len = 7).
  - rdata must be 0x41,0x72,0x6d,0x54,0x72,0x61,0x63,0x65 in order.
  - Each byte must arrive 2 cycles after its reg_read.
- Hold rready low 10 cycles on byte 2 of a read.
  - rvalid and rdata stay stable for all 10 cycles.
  - No further reg_read is issued until the handshake completes.
- Timeout build with pTIMEOUT = 16: withhold wvalid after byte 0.
  - Expect done with err = 1 exactly 16 cycles after entering WR.
  - Expect only one reg_write.
- Assert reset_n low during RHOLD of a 4-byte read.
  - All bus outputs go 0 immediately.
  - cmd_ready = 1, and no done pulse appears.
  - A new command after release completes normally.
- Assert cmd_valid continuously during a burst.
  - The second command is accepted only on the cycle after done.

Source files
------------

// File: rtl/reg_master_pkg.sv
// reg_master_pkg: shared state encoding and default sizing for the USB
// register bus initiator (reg_bus_master) and its optional stall counter.
package reg_master_pkg;

   localparam int unsigned ADDR_WIDTH_DEF   = 21;
   localparam int unsigned BYTECNT_SIZE_DEF = 7;
   localparam int unsigned TIMEOUT_DEF      = 1024;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_WR    = 3'd2,
      ST_WSTB  = 3'd3,
      ST_RD    = 3'd4,
      ST_RCAP  = 3'd5,
      ST_RHOLD = 3'd6,
      ST_DONE  = 3'd7
   } state_t;

endpackage

// File: rtl/reg_master_timeout.sv
// reg_master_timeout: stall counter for reg_bus_master. Reloads to pTIMEOUT
// whenever the master is outside a wait state (WR/RHOLD), counts down on each
// stalled cycle, and flags expiry on the stalled cycle whose decrement would
// reach zero, so the abort edge lands exactly pTIMEOUT cycles after entry.
module reg_master_timeout
   import reg_master_pkg::*;
#(
   parameter int unsigned pTIMEOUT = TIMEOUT_DEF
) (
   input  logic usb_clk,
   input  logic reset_n,
   input  logic armed,
   input  logic stalled,
   output logic expired
);

   localparam int unsigned CW = $clog2(pTIMEOUT + 1);

   logic [CW-1:0] count_r;

   // Reload outside the wait states, count down while the handshake stalls.
   always_ff @(posedge usb_clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= CW'(pTIMEOUT);
      end else if (!armed) begin
         count_r <= CW'(pTIMEOUT);
      end else if (stalled && (count_r != CW'(0))) begin
         count_r <= count_r - CW'(1);
      end
   end

   assign expired = armed && stalled && (count_r == CW'(1));

endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master: turns a command port plus valid/ready byte streams into
// byte-serial reg_address/reg_bytecnt/reg_read/reg_write bus accesses.
// Optional feature macro: REG_MASTER_TIMEOUT_EN adds a stall timeout that
// aborts a burst (done with err = 1); without it the block waits forever.
module reg_bus_master
   import reg_master_pkg::*;
#(
   parameter int unsigned pADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int unsigned pBYTECNT_SIZE = BYTECNT_SIZE_DEF,
   parameter int unsigned pTIMEOUT      = TIMEOUT_DEF
) (
   input  logic                                 usb_clk,
   input  logic                                 reset_n,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic                                 cmd_write,
   input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] cmd_address,
   input  logic [pBYTECNT_SIZE-1:0]             cmd_len,
   input  logic [7:0]                           wdata,
   input  logic                                 wvalid,
   output logic                                 wready,
   output logic [7:0]                           rdata,
   output logic                                 rvalid,
   input  logic                                 rready,
   output logic                                 done,
   output logic                                 err,
   output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
   output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
   output logic [7:0]                           reg_write_data,
   input  logic [7:0]                           reg_read_data,
   output logic                                 reg_read,
   output logic                                 reg_write,
   output logic                                 reg_addrvalid
);

   state_t                     state_r;
   logic                       write_r;
   logic [pBYTECNT_SIZE-1:0]   index_r;
   logic [pBYTECNT_SIZE-1:0]   last_r;
   logic                       expired_s;

`ifdef REG_MASTER_TIMEOUT_EN
   logic armed_s;
   logic stalled_s;

   assign armed_s   = (state_r == ST_WR) || (state_r == ST_RHOLD);
   assign stalled_s = ((state_r == ST_WR) && !wvalid) ||
                      ((state_r == ST_RHOLD) && !rready);

   reg_master_timeout #(
      .pTIMEOUT (pTIMEOUT)
   ) u_timeout (
      .usb_clk (usb_clk),
      .reset_n (reset_n),
      .armed   (armed_s),
      .stalled (stalled_s),
      .expired (expired_s)
   );
`else
   assign expired_s = 1'b0;
`endif

   // Burst sequencer: state, byte index and every registered output.
   always_ff @(posedge usb_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         write_r        <= 1'b0;
         index_r        <= '0;
         last_r         <= '0;
         cmd_ready      <= 1'b1;
         wready         <= 1'b0;
         rdata          <= 8'h00;
         rvalid         <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         reg_address    <= '0;
         reg_bytecnt    <= '0;
         reg_write_data <= 8'h00;
         reg_read       <= 1'b0;
         reg_write      <= 1'b0;
         reg_addrvalid  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmd_valid) begin
                  reg_address   <= cmd_address;
                  write_r       <= cmd_write;
                  last_r        <= cmd_len;
                  index_r       <= '0;
                  cmd_ready     <= 1'b0;
                  reg_addrvalid <= 1'b1;
                  reg_bytecnt   <= '0;
                  state_r       <= ST_SETUP;
               end else begin
                  cmd_ready     <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (write_r) begin
                  wready      <= 1'b1;
                  state_r     <= ST_WR;
               end else begin
                  reg_read    <= 1'b1;
                  reg_bytecnt <= index_r;
                  state_r     <= ST_RD;
               end
            end
            ST_WR: begin
               if (wvalid) begin
                  reg_write_data <= wdata;
                  wready         <= 1'b0;
                  reg_write      <= 1'b1;
                  reg_bytecnt    <= index_r;
                  state_r        <= ST_WSTB;
               end else if (expired_s) begin
                  wready         <= 1'b0;
                  reg_addrvalid  <= 1'b0;
                  done           <= 1'b1;
                  err            <= 1'b1;
                  state_r        <= ST_DONE;
               end
            end
            ST_WSTB: begin
               reg_write <= 1'b0;
               if (index_r == last_r) begin
                  reg_addrvalid <= 1'b0;
                  done          <= 1'b1;
                  err           <= 1'b0;
                  state_r       <= ST_DONE;
               end else begin
                  index_r       <= index_r + pBYTECNT_SIZE'(1);
                  wready        <= 1'b1;
                  state_r       <= ST_WR;
               end
            end
            ST_RD: begin
               reg_read <= 1'b0;
               state_r  <= ST_RCAP;
            end
            ST_RCAP: begin
               rdata   <= reg_read_data;
               rvalid  <= 1'b1;
               state_r <= ST_RHOLD;
            end
            ST_RHOLD: begin
               if (rready) begin
                  rvalid <= 1'b0;
                  if (index_r == last_r) begin
                     reg_addrvalid <= 1'b0;
                     done          <= 1'b1;
                     err           <= 1'b0;
                     state_r       <= ST_DONE;
                  end else begin
                     index_r       <= index_r + pBYTECNT_SIZE'(1);
                     reg_read      <= 1'b1;
                     reg_bytecnt   <= index_r + pBYTECNT_SIZE'(1);
                     state_r       <= ST_RD;
                  end
               end else if (expired_s) begin
                  // Abandon the pending byte along with the rest of the burst.
                  rvalid        <= 1'b0;
                  rdata         <= 8'h00;
                  reg_addrvalid <= 1'b0;
                  done          <= 1'b1;
                  err           <= 1'b1;
                  state_r       <= ST_DONE;
               end
            end
            ST_DONE: begin
               done      <= 1'b0;
               err       <= 1'b0;
               cmd_ready <= 1'b1;
               state_r   <= ST_IDLE;
            end
            default: begin
               wready        <= 1'b0;
               rvalid        <= 1'b0;
               reg_read      <= 1'b0;
               reg_write     <= 1'b0;
               reg_addrvalid <= 1'b0;
               done          <= 1'b0;
               err           <= 1'b0;
               cmd_ready     <= 1'b1;
               state_r       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: directed bench for reg_bus_master with a small register
// block model (pattern RAM plus an 8-byte name register) on the bus side.
module tb_reg_bus_master;

   localparam logic [13:0] PAT_ADDR  = 14'h0010;
   localparam logic [13:0] NAME_ADDR = 14'h0003;
   localparam logic [7:0]  NAME_BYTES [8] = '{8'h41, 8'h72, 8'h6d, 8'h54,
                                              8'h72, 8'h61, 8'h63, 8'h65};
   localparam logic [7:0]  PAT_BYTES  [8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                                              8'h00, 8'h00, 8'h00, 8'h00};
   localparam logic [7:0]  ONE_BYTE   [8] = '{8'h5A, 8'h00, 8'h00, 8'h00,
                                              8'h00, 8'h00, 8'h00, 8'h00};

   logic        usb_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [13:0] cmd_address = 14'h0000;
   logic [6:0]  cmd_len = 7'd0;
   logic [7:0]  wdata = 8'h00;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [7:0]  rdata;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        done;
   logic        err;
   logic [13:0] reg_address;
   logic [6:0]  reg_bytecnt;
   logic [7:0]  reg_write_data;
   logic [7:0]  reg_read_data = 8'h00;
   logic        reg_read;
   logic        reg_write;
   logic        reg_addrvalid;

   logic [7:0]  pat_mem [128];
   int          wr_count = 0;
   int          done_count = 0;
   int          errors = 0;
   int          checks = 0;

   reg_bus_master #(
      .pADDR_WIDTH   (21),
      .pBYTECNT_SIZE (7),
      .pTIMEOUT      (16)
   ) dut (
      .usb_clk        (usb_clk),
      .reset_n        (reset_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_write      (cmd_write),
      .cmd_address    (cmd_address),
      .cmd_len        (cmd_len),
      .wdata          (wdata),
      .wvalid         (wvalid),
      .wready         (wready),
      .rdata          (rdata),
      .rvalid         (rvalid),
      .rready         (rready),
      .done           (done),
      .err            (err),
      .reg_address    (reg_address),
      .reg_bytecnt    (reg_bytecnt),
      .reg_write_data (reg_write_data),
      .reg_read_data  (reg_read_data),
      .reg_read       (reg_read),
      .reg_write      (reg_write),
      .reg_addrvalid  (reg_addrvalid)
   );

   always #5 usb_clk = ~usb_clk;

   // Register block model: write on strobe, read data valid the cycle after.
   always @(posedge usb_clk) begin
      if (reg_write) begin
         if (reg_address == PAT_ADDR) pat_mem[reg_bytecnt] <= reg_write_data;
         wr_count <= wr_count + 1;
      end
      if (reg_read) begin
         if (reg_address == NAME_ADDR) reg_read_data <= NAME_BYTES[reg_bytecnt[2:0]];
         else                          reg_read_data <= pat_mem[reg_bytecnt];
      end
      if (done) done_count <= done_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Handshake exclusivity holds on every cycle out of reset.
   always @(negedge usb_clk) begin
      if (reset_n === 1'b1) begin
         check("excl_wready_rvalid", 32'(wready & rvalid), 32'd0);
         check("excl_read_write", 32'(reg_read & reg_write), 32'd0);
      end
   end

   // sel: 0 = wready, 1 = reg_read, 2 = done, 3 = cmd_ready
   task automatic wait_high(input int sel, input string tag);
      int n;
      logic v;
      n = 0;
      v = 1'b0;
      while (n < 100) begin
         case (sel)
            0: v = wready;
            1: v = reg_read;
            2: v = done;
            default: v = cmd_ready;
         endcase
         if (v === 1'b1) break;
         @(negedge usb_clk);
         n++;
      end
      check(tag, 32'(v), 32'd1);
   endtask

   task automatic issue_cmd(input logic wr, input logic [13:0] addr, input logic [6:0] len);
      cmd_write   = wr;
      cmd_address = addr;
      cmd_len     = len;
      cmd_valid   = 1'b1;
      wait_high(3, "cmd_ready_wait");
      @(negedge usb_clk);
      cmd_valid = 1'b0;
      check("setup_addrvalid", 32'(reg_addrvalid), 32'd1);
      check("setup_bytecnt", 32'(reg_bytecnt), 32'd0);
      check("setup_no_strobe", 32'({reg_read, reg_write}), 32'd0);
      check("setup_address", 32'(reg_address), 32'(addr));
      check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
   endtask

   task automatic write_burst(input logic [13:0] addr, input logic [6:0] len, input logic [7:0] data [8]);
      issue_cmd(1'b1, addr, len);
      for (int i = 0; i <= int'(len); i++) begin
         wait_high(0, "wready_wait");
         wdata  = data[i];
         wvalid = 1'b1;
         @(negedge usb_clk);
         wvalid = 1'b0;
         check("wstb_strobe", 32'(reg_write), 32'd1);
         check("wstb_bytecnt", 32'(reg_bytecnt), 32'(i));
         check("wstb_data", 32'(reg_write_data), 32'(data[i]));
         check("wstb_wready_low", 32'(wready), 32'd0);
      end
      @(negedge usb_clk);
      check("wr_done", 32'(done), 32'd1);
      check("wr_err", 32'(err), 32'd0);
      check("wr_done_addrvalid", 32'(reg_addrvalid), 32'd0);
      @(negedge usb_clk);
      check("wr_cmd_ready_back", 32'(cmd_ready), 32'd1);
      check("wr_done_one_cycle", 32'(done), 32'd0);
   endtask

   task automatic read_burst(input logic [13:0] addr, input logic [6:0] len, input logic [7:0] exp [8],
                             input int stall_byte, input int stall_cycles);
      issue_cmd(1'b0, addr, len);
      for (int i = 0; i <= int'(len); i++) begin
         if (i == 0) begin
            @(negedge usb_clk);
            check("first_strobe_2cyc", 32'(reg_read), 32'd1);
         end else begin
            wait_high(1, "rd_strobe_wait");
         end
         check("rd_bytecnt", 32'(reg_bytecnt), 32'(i));
         check("rd_rvalid_low", 32'(rvalid), 32'd0);
         @(negedge usb_clk);
         check("rcap_no_strobe", 32'(reg_read), 32'd0);
         @(negedge usb_clk);
         check("rhold_rvalid", 32'(rvalid), 32'd1);
         check("rhold_rdata", 32'(rdata), 32'(exp[i]));
         if (i == stall_byte) begin
            for (int k = 0; k < stall_cycles; k++) begin
               @(negedge usb_clk);
               check("stall_rvalid", 32'(rvalid), 32'd1);
               check("stall_rdata", 32'(rdata), 32'(exp[i]));
               check("stall_no_read", 32'(reg_read), 32'd0);
            end
         end
         rready = 1'b1;
         @(negedge usb_clk);
         rready = 1'b0;
         check("rd_rvalid_drop", 32'(rvalid), 32'd0);
      end
      check("rd_done", 32'(done), 32'd1);
      check("rd_err", 32'(err), 32'd0);
      @(negedge usb_clk);
      check("rd_cmd_ready_back", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int w0;
      for (int i = 0; i < 128; i++) pat_mem[i] = 8'h00;

      // Reset state
      @(negedge usb_clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_outputs", 32'({wready, rvalid, done, err, reg_read, reg_write, reg_addrvalid}), 32'd0);
      check("rst_bus", 32'({reg_address, reg_bytecnt, reg_write_data, rdata}), 32'd0);
      @(negedge usb_clk);
      reset_n = 1'b1;
      @(negedge usb_clk);

      // Four-byte write then read-back
      write_burst(PAT_ADDR, 7'd3, PAT_BYTES);
      check("pat_mem_3", 32'(pat_mem[3]), 32'h44);
      read_burst(PAT_ADDR, 7'd3, PAT_BYTES, -1, 0);

      // Name register, rready held low 10 cycles on byte 2
      read_burst(NAME_ADDR, 7'd7, NAME_BYTES, 2, 10);

`ifdef REG_MASTER_TIMEOUT_EN
      // Withhold wvalid after byte 0 of a 2-byte write
      w0 = wr_count;
      issue_cmd(1'b1, PAT_ADDR, 7'd1);
      wait_high(0, "to_wready_wait");
      wdata  = 8'h99;
      wvalid = 1'b1;
      @(negedge usb_clk);
      wvalid = 1'b0;
      check("to_first_strobe", 32'(reg_write), 32'd1);
      @(negedge usb_clk);
      check("to_in_wr", 32'(wready), 32'd1);
      for (int k = 1; k < 16; k++) begin
         @(negedge usb_clk);
         check("to_no_early_done", 32'(done), 32'd0);
      end
      @(negedge usb_clk);
      check("to_done", 32'(done), 32'd1);
      check("to_err", 32'(err), 32'd1);
      check("to_single_write", 32'(wr_count - w0), 32'd1);
      @(negedge usb_clk);
      check("to_cmd_ready", 32'(cmd_ready), 32'd1);
`endif

      // Reset during RHOLD of a 4-byte read
      issue_cmd(1'b0, PAT_ADDR, 7'd3);
      @(negedge usb_clk);
      check("rst_mid_strobe", 32'(reg_read), 32'd1);
      @(negedge usb_clk);
      @(negedge usb_clk);
      check("rst_mid_rhold", 32'(rvalid), 32'd1);
      d0 = done_count;
      reset_n = 1'b0;
      #1;
      check("rst_async_bus", 32'({reg_read, reg_write, reg_addrvalid, rvalid, wready, done, err}), 32'd0);
      check("rst_async_addr", 32'({reg_address, reg_bytecnt}), 32'd0);
      check("rst_async_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge usb_clk);
      @(negedge usb_clk);
      reset_n = 1'b1;
      @(negedge usb_clk);
      @(negedge usb_clk);
      check("rst_not_resumed", 32'({reg_addrvalid, reg_read}), 32'd0);
      check("rst_no_done", 32'(done_count - d0), 32'd0);
      write_burst(PAT_ADDR, 7'd0, ONE_BYTE);
      check("rst_after_write", 32'(pat_mem[0]), 32'h5A);

      // cmd_valid held high through a one-byte read
      rready      = 1'b1;
      cmd_write   = 1'b0;
      cmd_address = NAME_ADDR;
      cmd_len     = 7'd0;
      cmd_valid   = 1'b1;
      wait_high(3, "cv_ready_wait");
      @(negedge usb_clk);
      check("cv_busy", 32'(cmd_ready), 32'd0);
      wait_high(2, "cv_done_wait");
      check("cv_busy_at_done", 32'(cmd_ready), 32'd0);
      @(negedge usb_clk);
      check("cv_ready_after_done", 32'(cmd_ready), 32'd1);
      check("cv_idle_addrvalid", 32'(reg_addrvalid), 32'd0);
      @(negedge usb_clk);
      cmd_valid = 1'b0;
      check("cv_second_accepted", 32'(reg_addrvalid), 32'd1);
      check("cv_second_busy", 32'(cmd_ready), 32'd0);
      wait_high(2, "cv_second_done");
      check("cv_second_rdata", 32'(rdata), 32'h41);
      rready = 1'b0;
      @(negedge usb_clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
